// File: rtl/up_down_counter_param.sv
// up_down_counter_param: parametrised modulo-(MAX_VAL+1) up/down counter with step, load, enable, wrap/saturate.
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset (CNT <= RESET_VAL, flags cleared)
//   i_en       count enable
//   i_up       direction, 1 = up
//   i_step     amount per enabled cycle, clamped to MAX_VAL
//   i_load     synchronous load strobe, beats i_en
//   i_load_val load value, clamped to MAX_VAL
//   o_cnt      registered count, always within 0..MAX_VAL
//   o_tc       combinational terminal count for the current direction
//   o_wrap     one-cycle pulse aligned with a wrapping or clamping update
//   o_sat      sticky clamp flag, only ever set when SATURATE=1
module up_down_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 15,
    parameter int RESET_VAL = 1,
    parameter int SATURATE  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_sat
);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);
    // Truncates to 0 when MAX_VAL = 2^WIDTH-1, which is still correct for the modular wrap arithmetic below.
    localparam logic [WIDTH-1:0] L_MOD = WIDTH'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VAL);
    localparam logic             L_SAT = (SATURATE != 0);
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_sat;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_next;
    always_comb begin
        w_s    = (i_step > L_MAX) ? L_MAX : i_step;
        w_load = (i_load_val > L_MAX) ? L_MAX : i_load_val;
        // One extra bit so CNT+s can never overflow before the bound compare.
        w_sum  = {1'b0, r_cnt} + {1'b0, w_s};
        w_ovf  = i_up ? (w_sum > {1'b0, L_MAX}) : (r_cnt < w_s);
        // Wrapped results always lie in 0..MAX_VAL, so WIDTH-bit modular arithmetic gives the exact value.
        w_next = !w_ovf ? (i_up ? r_cnt + w_s : r_cnt - w_s) :
                 L_SAT  ? (i_up ? L_MAX : '0) :
                          (i_up ? r_cnt + w_s - L_MOD : r_cnt + L_MOD - w_s);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= L_RST;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= w_load;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (i_en) begin
            r_cnt  <= w_next;
            r_wrap <= w_ovf;
            r_sat  <= r_sat | (w_ovf & L_SAT);
        end else begin
            r_wrap <= 1'b0;
        end
    end
    assign o_cnt  = r_cnt;
    assign o_tc   = i_up ? (r_cnt == L_MAX) : (r_cnt == '0);
    assign o_wrap = r_wrap;
    assign o_sat  = r_sat;
endmodule

// File: tb/tb_up_down_counter_param.sv
// tb_up_down_counter_param: directed vectors on MAX_VAL=9 counters plus a reference-model run on MAX_VAL=199.
module tb_up_down_counter_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_en, a_up, a_load;
    logic [3:0] a_step, a_lv;
    logic [3:0] c0, c1;
    logic       tc0, tc1, w0, w1, s0, s1;

    logic       b_rst_n, b_en, b_up, b_load;
    logic [7:0] b_step, b_lv;
    logic [7:0] c2, c3;
    logic       tc2, tc3, w2, w3, s2, s3;

    int checks = 0;
    int errors = 0;

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(1), .SATURATE(0)) u0 (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_en(a_en), .i_up(a_up), .i_step(a_step),
        .i_load(a_load), .i_load_val(a_lv), .o_cnt(c0), .o_tc(tc0), .o_wrap(w0), .o_sat(s0));
    up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(1), .SATURATE(1)) u1 (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_en(a_en), .i_up(a_up), .i_step(a_step),
        .i_load(a_load), .i_load_val(a_lv), .o_cnt(c1), .o_tc(tc1), .o_wrap(w1), .o_sat(s1));
    up_down_counter_param #(.WIDTH(8), .MAX_VAL(199), .RESET_VAL(1), .SATURATE(0)) u2 (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_en(b_en), .i_up(b_up), .i_step(b_step),
        .i_load(b_load), .i_load_val(b_lv), .o_cnt(c2), .o_tc(tc2), .o_wrap(w2), .o_sat(s2));
    up_down_counter_param #(.WIDTH(8), .MAX_VAL(199), .RESET_VAL(1), .SATURATE(1)) u3 (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_en(b_en), .i_up(b_up), .i_step(b_step),
        .i_load(b_load), .i_load_val(b_lv), .o_cnt(c3), .o_tc(tc3), .o_wrap(w3), .o_sat(s3));

    typedef struct {
        logic       rst_n;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] step;
        int         d;
        int         cnt;
        logic       wrap;
        logic       sat;
        logic       tc;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst_n, input logic load, input int lv, input logic en,
                       input logic up, input int step, input int d, input int cnt,
                       input logic wrap, input logic sat, input logic tc);
        v.push_back('{rst_n, load, 4'(lv), en, up, 4'(step), d, cnt, wrap, sat, tc});
    endtask

    // Independent reference for the MAX_VAL=199 counters.
    task automatic model(input bit sat_mode, input logic rst_n, input logic load, input logic en,
                         input logic up, input int lv, input int step,
                         inout int cnt, inout bit wrap, inout bit sat);
        int s, t;
        s = (step > 199) ? 199 : step;
        if (!rst_n) begin
            cnt = 1; wrap = 0; sat = 0;
        end else if (load) begin
            cnt = (lv > 199) ? 199 : lv; wrap = 0; sat = 0;
        end else if (!en) begin
            wrap = 0;
        end else if (up) begin
            t = cnt + s;
            if (t > 199) begin
                cnt = sat_mode ? 199 : t - 200; wrap = 1; sat = sat | sat_mode;
            end else begin
                cnt = t; wrap = 0;
            end
        end else begin
            t = cnt - s;
            if (t < 0) begin
                cnt = sat_mode ? 0 : t + 200; wrap = 1; sat = sat | sat_mode;
            end else begin
                cnt = t; wrap = 0;
            end
        end
    endtask

    initial begin
        int m2, m3;
        bit mw2, mw3, ms2, ms3;
        a_rst_n = 0; a_load = 0; a_lv = 0; a_en = 0; a_up = 1; a_step = 0;
        b_rst_n = 0; b_load = 0; b_lv = 0; b_en = 0; b_up = 1; b_step = 0;

        // reset beats load, then idle hold
        add(0, 1, 7, 1, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 7, 1, 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        // wrap-mode count up by 1 through the terminal value
        for (int i = 2; i <= 8; i++) add(1, 0, 0, 1, 1, 1, 0, i, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 0, 9, 0, 0, 1);
        add(1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0);
        // wrap-mode count down by 3 from 2
        add(1, 1, 2, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 0, 0, 1, 0, 3, 0, 9, 1, 0, 0);
        add(1, 0, 0, 1, 0, 3, 0, 6, 0, 0, 0);
        add(1, 0, 0, 1, 0, 3, 0, 3, 0, 0, 0);
        add(1, 0, 0, 1, 0, 3, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 0, 3, 0, 7, 1, 0, 0);
        // saturate-mode clamp at MAX_VAL, sticky flag, cleared by load
        add(1, 1, 7, 0, 1, 0, 1, 7, 0, 0, 0);
        add(1, 0, 0, 1, 1, 4, 1, 9, 1, 1, 1);
        add(1, 0, 0, 1, 1, 4, 1, 9, 1, 1, 1);
        add(1, 0, 0, 0, 1, 4, 1, 9, 0, 1, 1);
        add(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // saturate-mode clamp at 0
        add(1, 1, 3, 0, 0, 0, 1, 3, 0, 0, 0);
        add(1, 0, 0, 1, 0, 5, 1, 0, 1, 1, 1);
        // load/step clamping and direction reversal
        add(1, 1, 15, 0, 0, 0, 0, 9, 0, 0, 0);
        add(1, 0, 0, 1, 0, 12, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 2, 0, 2, 0, 0, 0);
        add(1, 0, 0, 1, 1, 2, 0, 4, 0, 0, 0);
        add(1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
        add(1, 0, 0, 1, 1, 15, 0, 1, 1, 0, 0);

        foreach (v[i]) begin
            a_rst_n = v[i].rst_n; a_load = v[i].load; a_lv = v[i].lv;
            a_en = v[i].en; a_up = v[i].up; a_step = v[i].step;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.cnt", i), v[i].d == 0 ? 32'(c0) : 32'(c1), 32'(v[i].cnt));
            chk($sformatf("vec%0d.wrap", i), v[i].d == 0 ? 32'(w0) : 32'(w1), 32'(v[i].wrap));
            chk($sformatf("vec%0d.sat", i), v[i].d == 0 ? 32'(s0) : 32'(s1), 32'(v[i].sat));
            chk($sformatf("vec%0d.tc", i), v[i].d == 0 ? 32'(tc0) : 32'(tc1), 32'(v[i].tc));
        end

        // reset mid-count is synchronous only
        a_rst_n = 1; a_load = 1; a_lv = 3; a_en = 0; a_up = 1; a_step = 1;
        @(posedge clk); #1;
        a_load = 0; a_en = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst.pre", 32'(c0), 32'd5);
        a_rst_n = 0;
        #2;
        chk("midrst.async", 32'(c0), 32'd5);
        @(posedge clk); #1;
        chk("midrst.cnt", 32'(c0), 32'd1);
        chk("midrst.wrap", 32'(w0), 32'd0);
        a_rst_n = 1; a_en = 0;

        // random run against the reference model; b_rst_n has been low for many edges
        m2 = 1; m3 = 1; mw2 = 0; mw3 = 0; ms2 = 0; ms3 = 0;
        for (int i = 0; i < 2000; i++) begin
            b_rst_n = ($urandom_range(0, 49) != 0);
            b_load  = ($urandom_range(0, 15) == 0);
            b_en    = 1'($urandom);
            b_up    = 1'($urandom);
            b_step  = 8'($urandom_range(0, 255));
            b_lv    = 8'($urandom_range(0, 255));
            model(0, b_rst_n, b_load, b_en, b_up, b_lv, b_step, m2, mw2, ms2);
            model(1, b_rst_n, b_load, b_en, b_up, b_lv, b_step, m3, mw3, ms3);
            @(posedge clk); #1;
            chk("rnd.cnt0", 32'(c2), 32'(m2));
            chk("rnd.wrap0", 32'(w2), 32'(mw2));
            chk("rnd.sat0", 32'(s2), 32'(ms2));
            chk("rnd.tc0", 32'(tc2), 32'(b_up ? (m2 == 199) : (m2 == 0)));
            chk("rnd.cnt1", 32'(c3), 32'(m3));
            chk("rnd.wrap1", 32'(w3), 32'(mw3));
            chk("rnd.sat1", 32'(s3), 32'(ms3));
            chk("rnd.tc1", 32'(tc3), 32'(b_up ? (m3 == 199) : (m3 == 0)));
            chk("rnd.range", 32'(c2 > 8'd199 || c3 > 8'd199), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
